// File: rtl/encrypt_pipe_pkg.sv
// Shared types and helpers for the encryption pipeline.
package encrypt_pipe_pkg;

  localparam int          ENC_ROT_W = 3;
  localparam logic [23:0] KEY_RST   = 24'h0;

  typedef enum logic {IDLE, RUN} enc_state_t;

  typedef struct packed {
    logic [ENC_ROT_W-1:0] rot_freq;
    logic                 mode;
    logic                 shift_en;
    logic [2:0]           shift_amt;
    logic [7:0][2:0]      perm;
  } enc_cfg_t;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

endpackage

// File: rtl/encrypt_pipe_key_sched.sv
// Rotating key register; the current key byte is always bits [15:8].
module encrypt_pipe_key_sched
  import encrypt_pipe_pkg::*;
#(
  parameter int ROT_W     = 3,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [8*KEY_BYTES-1:0] load_key,
  input  logic                   adv,
  input  logic                   mode,
  input  logic [ROT_W-1:0]       rot_freq,
  output logic [7:0]             key_byte
);

  localparam int KW = 8 * KEY_BYTES;

  logic [KW-1:0]    key_q, key_d, key_base;
  logic [ROT_W-1:0] cnt_q, cnt_d, cnt_base;

  // A load and the first byte share a cycle, so the byte sees the loaded key.
  always_comb begin
    key_base = load ? load_key : key_q;
    cnt_base = load ? '0 : cnt_q;
    key_d    = key_base;
    cnt_d    = cnt_base;
    if (adv) begin
      if (cnt_base == rot_freq) begin
        cnt_d = '0;
        key_d = mode ? {key_base[7:0], key_base[KW-1:8]}
                     : {key_base[KW-9:0], key_base[KW-1:KW-8]};
      end else begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  assign key_byte = key_base[15:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q <= KEY_RST;
      cnt_q <= '0;
    end else begin
      key_q <= key_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/encrypt_pipe.sv
// Two-stage byte encryptor: permute, XOR rotating key, optional rotate-left.
// Optional ENC_BYTE_CNT_EN adds a saturating byte_cnt output of emitted bytes.
//   state | meaning
//   IDLE  | waiting; next en loads config/key from the inputs
//   RUN   | streaming with shadow config; flush returns to IDLE
module encrypt_pipe
  import encrypt_pipe_pkg::*;
#(
  parameter int ROT_W     = 3,
  parameter int KEY_BYTES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             en,
  input  logic             flush,
  input  logic [7:0]       k1,
  input  logic [7:0]       k2,
  input  logic [7:0]       k3,
  input  logic [ROT_W-1:0] rot_freq,
  input  logic             mode,
  input  logic             shift_en,
  input  logic [2:0]       shift_amt,
  input  logic [2:0]       perm0,
  input  logic [2:0]       perm1,
  input  logic [2:0]       perm2,
  input  logic [2:0]       perm3,
  input  logic [2:0]       perm4,
  input  logic [2:0]       perm5,
  input  logic [2:0]       perm6,
  input  logic [2:0]       perm7,
  output logic [7:0]       dout,
`ifdef ENC_BYTE_CNT_EN
  output logic [15:0]      byte_cnt,
`endif
  output logic             v
);

  enc_state_t      state_q;
  enc_cfg_t        shadow_q, cfg_in, cfg_eff;
  logic            load;
  logic [7:0]      key_byte;

  logic            v_s1_q, shift_en_s1_q;
  logic [7:0]      din_s1_q, key_s1_q;
  logic [2:0]      shift_amt_s1_q;
  logic [7:0][2:0] perm_s1_q;
  logic [7:0]      p, x, res;
  logic [7:0]      dout_q;
  logic            v_q;

  always_comb begin
    cfg_in.rot_freq  = rot_freq;
    cfg_in.mode      = mode;
    cfg_in.shift_en  = shift_en;
    cfg_in.shift_amt = shift_amt;
    cfg_in.perm      = {perm7, perm6, perm5, perm4, perm3, perm2, perm1, perm0};
  end

  assign load    = (state_q == IDLE) && en;
  assign cfg_eff = (state_q == IDLE) ? cfg_in : shadow_q;

  encrypt_pipe_key_sched #(.ROT_W(ROT_W), .KEY_BYTES(KEY_BYTES)) u_key_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_key ({k2, k3, k1}),
    .adv      (en),
    .mode     (cfg_eff.mode),
    .rot_freq (cfg_eff.rot_freq),
    .key_byte (key_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (en) begin
          shadow_q <= cfg_in;
          state_q  <= RUN;
        end
        RUN:  if (flush) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) p[i] = din_s1_q[perm_s1_q[i]];
    x   = p ^ key_s1_q;
    res = shift_en_s1_q ? rotl8(x, shift_amt_s1_q) : x;
  end

  // Bytes already in flight keep their captured key and settings across a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_s1_q         <= 1'b0;
      din_s1_q       <= '0;
      key_s1_q       <= '0;
      shift_en_s1_q  <= 1'b0;
      shift_amt_s1_q <= '0;
      perm_s1_q      <= '0;
      dout_q         <= '0;
      v_q            <= 1'b0;
    end else begin
      v_s1_q <= en;
      if (en) begin
        din_s1_q       <= din;
        key_s1_q       <= key_byte;
        shift_en_s1_q  <= cfg_eff.shift_en;
        shift_amt_s1_q <= cfg_eff.shift_amt;
        perm_s1_q      <= cfg_eff.perm;
      end
      v_q <= v_s1_q;
      if (v_s1_q) dout_q <= res;
    end
  end

  assign dout = dout_q;
  assign v    = v_q;

`ifdef ENC_BYTE_CNT_EN
  logic [15:0] byte_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     byte_cnt_q <= '0;
    else if (load)                                byte_cnt_q <= '0;
    else if (v_s1_q && (byte_cnt_q != 16'hFFFF))  byte_cnt_q <= byte_cnt_q + 16'd1;
  end

  assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_encrypt_pipe.sv
// Directed scoreboard bench for encrypt_pipe; expected bytes are hand-computed.
module tb_encrypt_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       en, flush;
  logic [7:0] k1, k2, k3;
  logic [2:0] rot_freq;
  logic       mode, shift_en;
  logic [2:0] shift_amt;
  logic [2:0] perm [8];
  logic [7:0] dout;
  logic       v;
`ifdef ENC_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  encrypt_pipe dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .flush(flush),
    .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq), .mode(mode),
    .shift_en(shift_en), .shift_amt(shift_amt),
    .perm0(perm[0]), .perm1(perm[1]), .perm2(perm[2]), .perm3(perm[3]),
    .perm4(perm[4]), .perm5(perm[5]), .perm6(perm[6]), .perm7(perm[7]),
    .dout(dout),
`ifdef ENC_BYTE_CNT_EN
    .byte_cnt(byte_cnt),
`endif
    .v(v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every v must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (v) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_v: dout=%02h at cycle %0d, nothing expected", dout, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.data !== dout || mon_e.due != cyc) begin
            bad++;
            $display("FAIL byte: dout=%02h at cycle %0d, required %02h at cycle %0d",
                     dout, cyc, mon_e.data, mon_e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        total++;
        bad++;
        mon_e = sb.pop_front();
        $display("FAIL missing_v: no v at cycle %0d, required %02h", cyc, mon_e.data);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic f, input logic [7:0] e);
    exp_t t;
    en    = 1'b1;
    din   = d;
    flush = f;
    t.data = e;
    t.due  = cyc + 2;
    sb.push_back(t);
    @(posedge clk); #1;
    en    = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // pm: 0 identity, 1 reversed, 2 all zero
  task automatic cfg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [2:0] rf, input logic m, input logic se,
                     input logic [2:0] sa, input int pm);
    k1 = a; k2 = b; k3 = c;
    rot_freq = rf; mode = m; shift_en = se; shift_amt = sa;
    for (int i = 0; i < 8; i++)
      perm[i] = (pm == 0) ? 3'(i) : (pm == 1) ? 3'(7 - i) : 3'd0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0; din = '0;
    cfg(8'h11, 8'h22, 8'h33, 3'd0, 1'b0, 1'b0, 3'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_v", {15'd0, v}, 16'd0);
    check("reset_dout", {8'd0, dout}, 16'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // mode 0, rot_freq 0: k3, k1, k2, k3, k1
    send(8'h00, 1'b0, 8'h33); send(8'h00, 1'b0, 8'h11); send(8'h00, 1'b0, 8'h22);
    send(8'h00, 1'b0, 8'h33); send(8'h00, 1'b0, 8'h11);
    do_flush();
    drain();
`ifdef ENC_BYTE_CNT_EN
    check("byte_cnt_5", byte_cnt, 16'd5);
`endif

    cfg(8'h11, 8'h22, 8'h33, 3'd0, 1'b1, 1'b0, 3'd0, 0);
    send(8'h00, 1'b0, 8'h33); send(8'h00, 1'b0, 8'h22); send(8'h00, 1'b0, 8'h11);
    send(8'h00, 1'b0, 8'h33);
    do_flush();

    cfg(8'h11, 8'h22, 8'h33, 3'd1, 1'b0, 1'b0, 3'd0, 0);
    send(8'h00, 1'b0, 8'h33); send(8'h00, 1'b0, 8'h33); send(8'h00, 1'b0, 8'h11);
    send(8'h00, 1'b0, 8'h11);
    do_flush();

    cfg(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 1);
    send(8'h01, 1'b0, 8'h80);
    do_flush();
    cfg(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 3'd3, 1);
    send(8'h01, 1'b0, 8'h04);
    do_flush();

    // duplicate perm entries: every output bit copies din[0]
    cfg(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 2);
    send(8'h01, 1'b0, 8'hFF); send(8'hFE, 1'b0, 8'h00);
    do_flush();

    // config changes in RUN ignored; flush+en byte uses old key
    cfg(8'h11, 8'h22, 8'h33, 3'd0, 1'b0, 1'b0, 3'd0, 0);
    send(8'h00, 1'b0, 8'h33);
    cfg(8'hA1, 8'hB2, 8'hC3, 3'd0, 1'b0, 1'b1, 3'd5, 0);
    send(8'h00, 1'b0, 8'h11);
    send(8'h00, 1'b1, 8'h22);
    shift_en = 1'b0;
    @(posedge clk); #1;
    send(8'h00, 1'b0, 8'hC3); send(8'h00, 1'b0, 8'hA1);
    do_flush();

    // nonzero data with rotate: 81^33=B2 rotl1=65; 5A^11=4B rotl1=96
    cfg(8'h11, 8'h22, 8'h33, 3'd0, 1'b0, 1'b1, 3'd1, 0);
    send(8'h81, 1'b0, 8'h65); send(8'h5A, 1'b0, 8'h96);
    do_flush();
    drain();

    // reset with bytes in flight
    cfg(8'h11, 8'h22, 8'h33, 3'd0, 1'b0, 1'b0, 3'd0, 0);
    en = 1'b1; din = 8'hAA;
    @(posedge clk); #1;
    din = 8'h55;
    @(posedge clk); #1;
    en = 1'b0;
    check("pre_rst_v", {15'd0, v}, 16'd1);
    check("pre_rst_dout", {8'd0, dout}, 16'h0099);
    rst = 1'b0;
    #1;
    check("rst_v_drop", {15'd0, v}, 16'd0);
    check("rst_dout_clr", {8'd0, dout}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_v", {15'd0, v}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
